axis_bram_sequencer: RTL
========================

AXIS_BRAM_SEQUENCER -- requirements
Module: axis_bram_sequencer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32: stream data width.
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 32: BRAM read data width.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH (AW), default 10: BRAM address width.
REQ-004 SHALL have parameter BRAM_READ_LATENCY (L), default 1, legal 1..2: cycles from address/enable to valid bram_porta_rddata.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: aclk, aresetn.
REQ-006 aclk  in  1  sole clock, all logic on rising edge.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 cfg_data  in  2*AW+17  [AW-1:0] start addr, [2AW-1:AW] stop addr, [2AW+15:2AW] repeat count (0 = infinite), [2AW+16] enable.
REQ-009 sts_data  out  AW+16  [AW-1:0] next address to issue, [AW+15:AW] completed passes.
REQ-010 m_axis_tready  in  1; m_axis_tdata  out  AXIS_TDATA_WIDTH; m_axis_tvalid  out  1; m_axis_tlast  out  1.
REQ-011 m_axis_config_tready  in  1; m_axis_config_tvalid  out  1  end-of-sequence event.
REQ-012 bram_porta_clk  out  1 (= aclk); bram_porta_rst  out  1 (= ~aresetn); bram_porta_en  out  1; bram_porta_addr  out  AW; bram_porta_rddata  in  BRAM_DATA_WIDTH.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN when enable sampled high; address loads start, pass counter loads 0.
REQ-015 A pass SHALL read start..stop inclusive, incrementing modulo 2^AW; stop < start wraps through 2^AW-1 to 0; start = stop gives one-word passes.
REQ-016 After issuing stop: pass counter increments; if repeat != 0 and counter reaches repeat -> DRAIN, else address reloads start with no bubble.
REQ-017 Enable low in RUN SHALL stop issue next cycle -> DRAIN; in-flight words still delivered; exit to IDLE without config event.
REQ-018 DRAIN -> DONE (normal completion) or IDLE (abort) once output FIFO and read pipeline are empty.
REQ-019 DONE SHALL hold m_axis_config_tvalid high until m_axis_config_tready, then -> IDLE only when enable is low; otherwise wait in DONE with tvalid low (no retrigger on held enable).
REQ-020 Reads SHALL be issued (bram_porta_en high, one address per cycle) only in RUN while FIFO occupancy + in-flight reads - (pop this cycle) < 4.
REQ-021 Returned data SHALL be written into a 4-entry output FIFO L cycles after issue, with tlast tag set for the word read from stop.
REQ-022 m_axis_tvalid = FIFO non-empty; pop on tvalid & tready; tdata/tlast stable while tvalid & ~tready.
REQ-023 tdata SHALL be rddata zero-extended or truncated (LSBs kept) to AXIS_TDATA_WIDTH.
REQ-024 Enable high sampled in IDLE at cycle N: first issue N+1, first tvalid N+2+L.
REQ-025 With tready held high, throughput SHALL be one beat per cycle, including across pass boundaries, for L = 1 and 2.
REQ-026 cfg_data fields SHALL be sampled only at IDLE->RUN; later changes ignored until next run.
REQ-027 Infinite mode: completed-pass counter wraps at 2^16.

Reset
REQ-028 aresetn low SHALL immediately force IDLE, FIFO empty, in-flight cleared, counters 0, m_axis_tvalid/tlast/config_tvalid/bram_porta_en 0, bram_porta_addr 0.
REQ-029 Reset mid-RUN SHALL discard all pending words; no beat emitted after release until new enable.

Verification
REQ-030 L=1, start=2, stop=5, repeat=2, tready=1 -> 8 beats addr 2,3,4,5,2,3,4,5, tlast on beats 4 and 8, one config_tvalid pulse, sts passes=2.
REQ-031 L=2, start=1020, stop=3, AW=10, repeat=1 -> 8 beats 1020..1023,0..3, tlast on last only.
REQ-032 tready random 50% -> data order and tlast positions identical to REQ-030; tdata held during stalls; at most 4 outstanding.
REQ-033 repeat=0, enable dropped after 13 beats issued -> all issued words delivered, no config_tvalid, state IDLE.
REQ-034 aresetn low during RUN with full FIFO -> tvalid 0 same cycle; after release, no output until enable re-asserted.

Source files
------------

// File: rtl/axis_bram_sequencer.sv
// rtl/axis_bram_sequencer.sv - BRAM read sequencer streaming start..stop address passes over AXI-Stream
module axis_bram_sequencer #(
    parameter int AXIS_TDATA_WIDTH  = 32,
    parameter int BRAM_DATA_WIDTH   = 32,
    parameter int BRAM_ADDR_WIDTH   = 10,
    parameter int BRAM_READ_LATENCY = 1
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [2*BRAM_ADDR_WIDTH+16:0]     cfg_data,
    output logic [BRAM_ADDR_WIDTH+15:0]       sts_data,
    input  logic                              m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_config_tready,
    output logic                              m_axis_config_tvalid,
    output logic                              bram_porta_clk,
    output logic                              bram_porta_rst,
    output logic                              bram_porta_en,
    output logic [BRAM_ADDR_WIDTH-1:0]        bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]        bram_porta_rddata
);
    localparam int AW    = BRAM_ADDR_WIDTH;
    localparam int L     = BRAM_READ_LATENCY;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state;
    logic [AW-1:0]               start_addr;
    logic [AW-1:0]               stop_addr;
    logic [AW-1:0]               addr;
    logic [15:0]                 repeat_cnt;
    logic [15:0]                 passes;
    logic                        abort;
    logic                        cfg_enable;

    logic [L-1:0]                pipe_vld;
    logic [L-1:0]                pipe_last;
    logic [2:0]                  inflight;
    logic [AXIS_TDATA_WIDTH:0]   mem [DEPTH];
    logic [1:0]                  wr_ptr;
    logic [1:0]                  rd_ptr;
    logic [2:0]                  count;
    logic [3:0]                  load;
    logic                        pop;
    logic                        push;
    logic                        issue;
    logic                        last_issue;
    logic                        finish;
    logic [AXIS_TDATA_WIDTH-1:0] rd_word;

    assign cfg_enable = cfg_data[2*AW+16];

    generate
        if (AXIS_TDATA_WIDTH > BRAM_DATA_WIDTH) begin : g_extend
            assign rd_word = {{(AXIS_TDATA_WIDTH-BRAM_DATA_WIDTH){1'b0}}, bram_porta_rddata};
        end else begin : g_trunc
            assign rd_word = bram_porta_rddata[AXIS_TDATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + {2'b0, pipe_vld[i]};
        end
    end

    // Everything already committed (queued or in the BRAM pipe) must fit in the FIFO.
    assign load       = {1'b0, count} + {1'b0, inflight} - {3'b0, pop};
    assign issue      = (state == RUN) && (load < 4'd4);
    assign last_issue = issue && (addr == stop_addr);
    assign finish     = last_issue && (repeat_cnt != 16'd0) && (passes + 16'd1 == repeat_cnt);

    assign push          = pipe_vld[L-1];
    assign m_axis_tvalid = (count != 3'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = mem[rd_ptr][AXIS_TDATA_WIDTH-1:0];
    assign m_axis_tlast  = m_axis_tvalid && mem[rd_ptr][AXIS_TDATA_WIDTH];

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_en   = issue;
    assign bram_porta_addr = addr;
    assign sts_data        = {passes, addr};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_last[0] <= last_issue;
            for (int i = 1; i < L; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            if (push) begin
                mem[wr_ptr] <= {pipe_last[L-1], rd_word};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                <= IDLE;
            start_addr           <= '0;
            stop_addr            <= '0;
            addr                 <= '0;
            repeat_cnt           <= '0;
            passes               <= '0;
            abort                <= 1'b0;
            m_axis_config_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        start_addr <= cfg_data[AW-1:0];
                        stop_addr  <= cfg_data[2*AW-1:AW];
                        repeat_cnt <= cfg_data[2*AW+15:2*AW];
                        addr       <= cfg_data[AW-1:0];
                        passes     <= '0;
                        abort      <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_issue) begin
                            passes <= passes + 16'd1;
                            addr   <= start_addr;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                    // A pass that completes on the same edge as the disable still counts as finished.
                    if (finish) begin
                        state <= DRAIN;
                    end else if (!cfg_enable) begin
                        abort <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == 3'd0 && inflight == 3'd0) begin
                        if (abort) begin
                            state <= IDLE;
                        end else begin
                            m_axis_config_tvalid <= 1'b1;
                            state                <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (m_axis_config_tvalid) begin
                        if (m_axis_config_tready) begin
                            m_axis_config_tvalid <= 1'b0;
                            if (!cfg_enable) begin
                                state <= IDLE;
                            end
                        end
                    end else if (!cfg_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
